// File: rtl/and_gate_operand_sequencer.sv
// Operand sweep source for my_and_gate: walks every (a,b) pair in index order,
// holding each for HOLD_CYCLES valid clocks, with start/pause/done control.
module and_gate_operand_sequencer #(
    parameter int OPERAND_WIDTH = 1,
    parameter int HOLD_CYCLES   = 1,
    parameter int IDX_WIDTH     = 2 * OPERAND_WIDTH
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     start_in,
    input  logic                     pause_in,
    output logic [OPERAND_WIDTH-1:0] a_out,
    output logic [OPERAND_WIDTH-1:0] b_out,
    output logic                     valid_out,
    output logic [IDX_WIDTH-1:0]     vec_index_out,
    output logic                     last_out,
    output logic                     busy_out,
    output logic                     done_out
);

    if (OPERAND_WIDTH < 1 || OPERAND_WIDTH > 8) begin : g_bad_width
        $fatal(1, "OPERAND_WIDTH out of range 1..8");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $fatal(1, "HOLD_CYCLES out of range 1..255");
    end
    if (IDX_WIDTH != 2 * OPERAND_WIDTH) begin : g_bad_idx
        $fatal(1, "IDX_WIDTH must equal 2*OPERAND_WIDTH");
    end

    localparam logic [7:0]           HOLD_MAX = 8'(HOLD_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] K_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0] r_k, w_k_nxt;
    logic [7:0]           r_cnt, w_cnt_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_last, w_last_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A held (paused) edge defers its count step, so resuming edges
    // perform it and the paused cycles never count toward the hold.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    w_state_nxt = S_RUN;
                    w_k_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_done_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (pause_in) begin
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = 1'b1;
                    if (r_cnt < HOLD_MAX) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end else if (r_k != K_MAX) begin
                        w_k_nxt   = r_k + 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_k_nxt     = '0;
                        w_cnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
        w_last_nxt = w_valid_nxt && (w_k_nxt == K_MAX);
        w_busy_nxt = (w_state_nxt == S_RUN);
    end

    assign a_out         = r_k[OPERAND_WIDTH-1:0];
    assign b_out         = r_k[IDX_WIDTH-1:OPERAND_WIDTH];
    assign valid_out     = r_valid;
    assign vec_index_out = r_k;
    assign last_out      = r_last;
    assign busy_out      = r_busy;
    assign done_out      = r_done;

endmodule

// File: tb/tb_and_gate_operand_sequencer.sv
// Scoreboard bench for and_gate_operand_sequencer across four
// width/hold configurations sharing one clock and reset.
module tb_and_gate_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] st;
    logic [3:0] pz;

    logic       a0, b0, v0, l0, bz0, d0;
    logic [1:0] k0;
    logic       a1, b1, v1, l1, bz1, d1;
    logic [1:0] k1;
    logic       a2, b2, v2, l2, bz2, d2;
    logic [1:0] k2;
    logic [1:0] a3, b3;
    logic [3:0] k3;
    logic       v3, l3, bz3, d3;

    and_gate_operand_sequencer #(.OPERAND_WIDTH(1), .HOLD_CYCLES(1)) u_d11 (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(st[0]),
        .pause_in(pz[0]), .a_out(a0), .b_out(b0), .valid_out(v0),
        .vec_index_out(k0), .last_out(l0), .busy_out(bz0),
        .done_out(d0));
    and_gate_operand_sequencer #(.OPERAND_WIDTH(1), .HOLD_CYCLES(3)) u_d13 (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(st[1]),
        .pause_in(pz[1]), .a_out(a1), .b_out(b1), .valid_out(v1),
        .vec_index_out(k1), .last_out(l1), .busy_out(bz1),
        .done_out(d1));
    and_gate_operand_sequencer #(.OPERAND_WIDTH(1), .HOLD_CYCLES(2)) u_d12 (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(st[2]),
        .pause_in(pz[2]), .a_out(a2), .b_out(b2), .valid_out(v2),
        .vec_index_out(k2), .last_out(l2), .busy_out(bz2),
        .done_out(d2));
    and_gate_operand_sequencer #(.OPERAND_WIDTH(2), .HOLD_CYCLES(1)) u_d21 (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(st[3]),
        .pause_in(pz[3]), .a_out(a3), .b_out(b3), .valid_out(v3),
        .vec_index_out(k3), .last_out(l3), .busy_out(bz3),
        .done_out(d3));

    int         sel;
    logic [1:0] m_a, m_b;
    logic [3:0] m_k;
    logic       m_v, m_l, m_bz, m_d;

    always_comb begin
        m_a = '0; m_b = '0; m_k = '0;
        m_v = 1'b0; m_l = 1'b0; m_bz = 1'b0; m_d = 1'b0;
        case (sel)
            0: begin
                m_a = {1'b0, a0}; m_b = {1'b0, b0}; m_k = {2'b0, k0};
                m_v = v0; m_l = l0; m_bz = bz0; m_d = d0;
            end
            1: begin
                m_a = {1'b0, a1}; m_b = {1'b0, b1}; m_k = {2'b0, k1};
                m_v = v1; m_l = l1; m_bz = bz1; m_d = d1;
            end
            2: begin
                m_a = {1'b0, a2}; m_b = {1'b0, b2}; m_k = {2'b0, k2};
                m_v = v2; m_l = l2; m_bz = bz2; m_d = d2;
            end
            default: begin
                m_a = a3; m_b = b3; m_k = k3;
                m_v = v3; m_l = l3; m_bz = bz3; m_d = d3;
            end
        endcase
    end

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] k;
        logic       l;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    logic p_d = 1'b0;
    logic p_l = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_v) begin
            nvalid++;
            if (q.size() == 0) begin
                chk("extra_valid", {31'b0, m_v}, 32'd0);
            end else begin
                vec_t e;
                e = q.pop_front();
                chk("vec", {23'b0, m_a, m_b, m_k, m_l}, {23'b0, e});
            end
            chk("busy_while_valid", {31'b0, m_bz}, 32'd1);
        end
        if (rst_n && m_d && !p_d)
            chk("done_after_last", {31'b0, p_l}, 32'd1);
        p_d = m_d;
        p_l = m_l;
    end

    task automatic push_sweep(input int w, input int h);
        int n;
        n = 1 << (2 * w);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < h; j++) begin
                vec_t e;
                e.a = 2'(k & ((1 << w) - 1));
                e.b = 2'(k >> w);
                e.k = 4'(k);
                e.l = (k == n - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int s);
        st[s] = 1'b1;
        @(negedge clk);
        st[s] = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (m_d) break;
            @(negedge clk);
        end
        chk("done_seen", {31'b0, m_d}, 32'd1);
        chk("done_busy", {31'b0, m_bz}, 32'd0);
        chk("done_ab_k", {24'b0, m_a, m_b, m_k}, 32'd0);
        chk("done_vl", {30'b0, m_v, m_l}, 32'd0);
        chk("q_drained", q.size(), 32'd0);
    endtask

    task automatic run_sweep(input int s, input int w, input int h);
        sel = s;
        @(negedge clk);
        q.delete();
        nvalid = 0;
        push_sweep(w, h);
        pulse_start(s);
        wait_done(200);
        chk("valid_total", nvalid, 32'((1 << (2 * w)) * h));
    endtask

    initial begin
        sel   = 0;
        st    = '0;
        pz    = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outs", {24'b0, m_a, m_b, m_k}, 32'd0);
        chk("rst_flags", {28'b0, m_v, m_l, m_bz, m_d}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // defaults: 4 vectors, 1 clock each
        run_sweep(0, 1, 1);
        // long hold
        run_sweep(1, 1, 3);

        // pause two clocks during the first hold cycle of k=1
        sel = 2;
        @(negedge clk);
        q.delete();
        nvalid = 0;
        push_sweep(1, 2);
        pulse_start(2);
        for (int i = 0; i < 50; i++) begin
            if (m_k == 4'd1) break;
            @(negedge clk);
        end
        chk("pause_at_k1", {28'b0, m_k}, 32'd1);
        pz[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pause_valid", {31'b0, m_v}, 32'd0);
            chk("pause_ab", {28'b0, m_a, m_b}, 32'h4);
        end
        pz[2] = 1'b0;
        wait_done(100);
        chk("pause_total", nvalid, 32'd8);

        // asynchronous reset mid-sweep at k=2
        sel = 0;
        @(negedge clk);
        q.delete();
        nvalid = 0;
        push_sweep(1, 1);
        pulse_start(0);
        for (int i = 0; i < 20; i++) begin
            if (m_k == 4'd2) break;
            @(negedge clk);
        end
        chk("pre_rst_k2", {28'b0, m_k}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {24'b0, m_a, m_b, m_k}, 32'd0);
        chk("async_rst_flags", {28'b0, m_v, m_l, m_bz, m_d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 1, 1);

        // start held throughout RUN, then a single pulse in DONE
        @(negedge clk);
        q.delete();
        nvalid = 0;
        push_sweep(1, 1);
        st[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_l) break;
        end
        st[0] = 1'b0;
        wait_done(20);
        chk("held_start_total", nvalid, 32'd4);
        @(negedge clk);
        chk("done_level", {31'b0, m_d}, 32'd1);
        nvalid = 0;
        push_sweep(1, 1);
        pulse_start(0);
        chk("restart_done_clr", {31'b0, m_d}, 32'd0);
        chk("restart_k0", {27'b0, m_k, m_v}, 32'd1);
        wait_done(20);
        chk("restart_total", nvalid, 32'd4);

        // two-bit operands: 16 vectors
        run_sweep(3, 2, 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_gate_operand_sequencer.md
Name: and_gate_operand_sequencer

Overview:
Upstream stimulus stage for my_and_gate. It drives the a_in/b_in operand pair, stepping through every operand combination in a fixed order. Each vector is held for a programmable number of clocks. The run is start-triggered, pausable, and reports progress and completion so the downstream gate and any result checker can align to each vector.

Parameters:
OPERAND_WIDTH, 1, width of each operand; matches INPUT_WIDTH of my_and_gate; legal range 1..8
HOLD_CYCLES, 1, valid clocks each vector is presented; legal range 1..255
IDX_WIDTH, 2*OPERAND_WIDTH, derived width of the vector index; not overridden

Ports:
clock_in  input  1  single clock; all state on rising edge
reset_n_in  input  1  asynchronous, active-low reset
start_in  input  1  begin a sweep; sampled in IDLE and DONE only
pause_in  input  1  freeze sweep while high in RUN
a_out  output  OPERAND_WIDTH  operand A to my_and_gate a_in
b_out  output  OPERAND_WIDTH  operand B to my_and_gate b_in
valid_out  output  1  a_out/b_out carry an active vector this cycle
vec_index_out  output  IDX_WIDTH  index k of the presented vector
last_out  output  1  presented vector is the final one (k = 2^IDX_WIDTH-1)
busy_out  output  1  state is RUN
done_out  output  1  sweep complete; level, held until next start or reset

Behaviour:
- Interface: one clock, clock_in. Reset is reset_n_in, asynchronous, active-low. Assertion clears all state immediately, independent of clock.
- Reset values: state IDLE; a_out, b_out, vec_index_out, hold counter = 0; valid_out, last_out, busy_out, done_out = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Vector mapping: a_out = k[OPERAND_WIDTH-1:0]; b_out = k[IDX_WIDTH-1:OPERAND_WIDTH]. With W=1 the order is (a,b) = (0,0), (1,0), (0,1), (1,1).
- States are IDLE, RUN and DONE.
- IDLE:
  - start_in=1 at edge N moves to RUN.
  - From edge N: k=0, valid_out=1, busy_out=1, hold counter=0.
- RUN, pause_in=0 at an edge:
  - If hold counter < HOLD_CYCLES-1, increment the counter.
  - Else if k < max, increment k and clear the counter.
  - Else (final cycle of last vector) go to DONE.
- RUN, pause_in=1 at an edge: k and the counter hold. valid_out is 0 for the following cycle; a_out/b_out keep their values. When pause_in drops, valid_out returns to 1 on the next edge and the remaining hold count resumes (a paused cycle is not counted).
- Total valid cycles per sweep = 2^IDX_WIDTH * HOLD_CYCLES, regardless of pauses.
- last_out = valid_out AND (k = 2^IDX_WIDTH-1).
- Entry to DONE: done_out=1, busy_out=0, valid_out=0, last_out=0; a_out, b_out, vec_index_out return to 0.
- DONE: start_in=1 clears done_out and re-enters RUN at k=0, with the same timing as from IDLE.
- start_in in RUN is ignored; no restart mid-sweep.
- start_in and pause_in both high in IDLE: start wins. pause_in applies from the first RUN edge.
- Wrap-around: the k increment never wraps; the transition to DONE happens instead.
- Reset mid-RUN: immediate return to reset values. A later start begins at k=0.
- Elaboration check: fatal if OPERAND_WIDTH or HOLD_CYCLES is outside its legal range.

Test Plan:
1. Defaults (W=1, H=1): reset low 1 clk, release, start 1 clk.
   -> valid_out high 4 clocks; (a,b) = (0,0), (1,0), (0,1), (1,1); vec_index_out 0..3; last_out only on the 4th.
   -> Next edge: done_out=1, a/b=0.
   -> my_and_gate c_out follows with its own latency: 0, 0, 0, 1.
2. W=1, H=3, no pause.
   -> Each vector is held exactly 3 valid clocks; 12 valid clocks total.
   -> done_out rises on the edge after the 12th.
3. H=2: pulse pause_in for 2 clocks during the first hold cycle of k=1.
   -> valid_out=0 for 2 cycles with a=1, b=0 held.
   -> k=1 still gets 2 valid clocks; 8 valid clocks total.
4. Assert reset_n_in asynchronously between edges while k=2.
   -> All outputs 0 before the next edge.
   -> A following start restarts at k=0 and completes normally.
5. start_in held high throughout RUN, then one start pulse in DONE.
   -> No restart during RUN.
   -> The pulse in DONE clears done_out and replays from k=0 in the next cycle.
6. W=2, H=1: one sweep.
   -> 16 vectors with a_out = k[1:0], b_out = k[3:2]; k=15 gives a=3, b=3 with last_out=1.
